// File: rtl/varredura_matriz_irrigacao.sv
// Column-scan controller for the 5x7 irrigation LED matrix: one-hot column select
// with programmable dwell, blank gap between columns, and per-frame mode latching.
module varredura_matriz_irrigacao #(
    parameter int DIV       = 50000,
    parameter int BLANK_CYC = 2,
    parameter int CW        = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       aspersao_in,
    input  logic       gotejamento_in,
    output logic [4:0] col,
    output logic [2:0] col_idx,
    output logic       aspersao,
    output logic       gotejamento,
    output logic       frame_fim
);

    typedef enum logic [1:0] {IDLE, LATCH, SHOW, BLANK} state_t;

    localparam logic [CW-1:0] DIV_LAST   = CW'(DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = (BLANK_CYC > 0) ? CW'(BLANK_CYC - 1) : '0;

    state_t        state_q, state_n;
    logic [CW-1:0] cnt_q, cnt_n;
    logic [2:0]    idx_q, idx_n;
    logic          asp_q, asp_n;
    logic          got_q, got_n;
    logic [4:0]    col_n;
    logic          ff_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            asp_q     <= 1'b0;
            got_q     <= 1'b0;
            col       <= '0;
            frame_fim <= 1'b0;
        end else begin
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            idx_q     <= idx_n;
            asp_q     <= asp_n;
            got_q     <= got_n;
            col       <= col_n;
            frame_fim <= ff_n;
        end
    end

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        idx_n   = idx_q;
        asp_n   = asp_q;
        got_n   = got_q;

        case (state_q)
            IDLE: begin
                cnt_n = '0;
                idx_n = '0;
                if (en) state_n = LATCH;
            end
            LATCH: begin
                asp_n   = aspersao_in;
                got_n   = gotejamento_in;
                idx_n   = '0;
                cnt_n   = '0;
                state_n = SHOW;
            end
            SHOW: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_n = '0;
                    if (BLANK_CYC > 0) begin
                        state_n = BLANK;
                    end else if (idx_q == 3'd4) begin
                        state_n = LATCH;
                        idx_n   = '0;
                    end else begin
                        idx_n = idx_q + 3'd1;
                    end
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    cnt_n = '0;
                    if (idx_q == 3'd4) begin
                        state_n = LATCH;
                        idx_n   = '0;
                    end else begin
                        state_n = SHOW;
                        idx_n   = idx_q + 3'd1;
                    end
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        // Dropping enable abandons the frame; the latched mode pair is kept.
        if (state_q != IDLE && !en) begin
            state_n = IDLE;
            cnt_n   = '0;
            idx_n   = '0;
            asp_n   = asp_q;
            got_n   = got_q;
        end

        // Outputs are registered, so they are derived from the next state.
        col_n = (state_n == SHOW) ? (5'b00001 << idx_n) : 5'b00000;
        ff_n  = (state_n == SHOW) && (idx_n == 3'd4) && (cnt_n == DIV_LAST);
    end

    assign col_idx     = idx_q;
    assign aspersao    = asp_q;
    assign gotejamento = got_q;

endmodule

// File: tb/tb_varredura_matriz_irrigacao.sv
// Randomized self-checking bench: two scan controllers (with and without blank gap)
// compared every cycle against a frame-position reference model.
module tb_varredura_matriz_irrigacao;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, en, aspersao_in, gotejamento_in;
    logic [4:0] col_a, col_b;
    logic [2:0] idx_a, idx_b;
    logic asp_a, asp_b, got_a, got_b, ff_a, ff_b;

    varredura_matriz_irrigacao #(.DIV(3), .BLANK_CYC(1), .CW(16)) dut_a (
        .clk(clk), .reset(reset), .en(en),
        .aspersao_in(aspersao_in), .gotejamento_in(gotejamento_in),
        .col(col_a), .col_idx(idx_a), .aspersao(asp_a),
        .gotejamento(got_a), .frame_fim(ff_a)
    );

    varredura_matriz_irrigacao #(.DIV(1), .BLANK_CYC(0), .CW(16)) dut_b (
        .clk(clk), .reset(reset), .en(en),
        .aspersao_in(aspersao_in), .gotejamento_in(gotejamento_in),
        .col(col_b), .col_idx(idx_b), .aspersao(asp_b),
        .gotejamento(got_b), .frame_fim(ff_b)
    );

    int n_vectors = 0;
    int n_miscompares = 0;

    // Reference model: each instance is either idle or at a position within its frame.
    // Position 0 is the latch cycle; the rest is five columns of DIV lit + BLANK_CYC dark.
    int div_p[2]   = '{3, 1};
    int blank_p[2] = '{1, 0};
    bit m_active[2];
    int m_pos[2];
    bit m_asp[2];
    bit m_got[2];

    task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
        n_vectors++;
        if (actual !== expected) begin
            n_miscompares++;
            $display("[TB] FAIL %s: observed %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    function automatic void expected_outputs(input int i, output logic [4:0] e_col,
                                             output logic [2:0] e_idx, output logic e_ff);
        int per, k, column, offset;
        e_col = '0;
        e_idx = '0;
        e_ff  = 1'b0;
        if (m_active[i] && m_pos[i] != 0) begin
            per    = div_p[i] + blank_p[i];
            k      = m_pos[i] - 1;
            column = k / per;
            offset = k % per;
            e_idx  = 3'(column);
            if (offset < div_p[i]) e_col = 5'(1 << column);
            e_ff   = (column == 4) && (offset == div_p[i] - 1);
        end
    endfunction

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            int period;
            period = 1 + 5 * (div_p[i] + blank_p[i]);
            if (reset) begin
                m_active[i] = 1'b0;
                m_pos[i]    = 0;
                m_asp[i]    = 1'b0;
                m_got[i]    = 1'b0;
            end else if (!en) begin
                m_active[i] = 1'b0;
                m_pos[i]    = 0;
            end else if (!m_active[i]) begin
                m_active[i] = 1'b1;
                m_pos[i]    = 0;
            end else begin
                if (m_pos[i] == 0) begin
                    m_asp[i] = aspersao_in;
                    m_got[i] = gotejamento_in;
                end
                m_pos[i] = (m_pos[i] + 1) % period;
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            logic [4:0] oc, ec;
            logic [2:0] oi, ei;
            logic oa, og, of, ef;
            if (i == 0) {oc, oi, oa, og, of} = {col_a, idx_a, asp_a, got_a, ff_a};
            else        {oc, oi, oa, og, of} = {col_b, idx_b, asp_b, got_b, ff_b};
            expected_outputs(i, ec, ei, ef);
            checkOutput($sformatf("col[%0d]", i), 8'(oc), 8'(ec));
            checkOutput($sformatf("col_idx[%0d]", i), 8'(oi), 8'(ei));
            checkOutput($sformatf("aspersao[%0d]", i), 8'(oa), 8'(m_asp[i]));
            checkOutput($sformatf("gotejamento[%0d]", i), 8'(og), 8'(m_got[i]));
            checkOutput($sformatf("frame_fim[%0d]", i), 8'(of), 8'(ef));
            checkOutput($sformatf("col_onehot[%0d]", i), 8'($countones(oc) <= 1), 8'd1);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic e, input logic a, input logic g, input int cycles);
        repeat (cycles) begin
            reset          = r;
            en             = e;
            aspersao_in    = a;
            gotejamento_in = g;
            @(posedge clk);
            model_step();
            @(negedge clk);
            check_all();
        end
    endtask

    // Holds the inputs until dut_a shows the requested column, bounded by a cycle budget.
    task automatic run_until_col(input logic [4:0] target, input logic a, input logic g, input int limit);
        int n;
        n = 0;
        while (col_a !== target && n < limit) begin
            applyStimulus(1'b0, 1'b1, a, g, 1);
            n++;
        end
        if (col_a !== target) checkOutput("wait_col_timeout", 8'(col_a), 8'(target));
    endtask

    initial begin
        logic r, e, a, g;
        $display("[TB] starting varredura_matriz_irrigacao bench");

        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 10);

        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 2);
        run_until_col(5'b00100, 1'b1, 1'b0, 40);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 50);

        run_until_col(5'b00100, 1'b0, 1'b1, 40);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 30);

        run_until_col(5'b01000, 1'b1, 1'b1, 40);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 30);

        a = 1'b0;
        g = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            r = ($urandom_range(63) == 0);
            e = ($urandom_range(31) != 0);
            if ($urandom_range(7) == 0) begin
                a = 1'($urandom_range(1));
                g = 1'($urandom_range(1));
            end
            applyStimulus(r, e, a, g, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
